mult_share_arbiter: RTL

MULT_SHARE_ARBITER -- requirements
Module: mult_share_arbiter

---
 rtl/mult_share_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/mult_share_arbiter.sv
// Four requesters share one 16x16 Wallace-tree multiplier through a round-robin
// arbiter feeding a two-stage pipeline (operands in S1, product in S2).
module mult_share_arbiter #(
  parameter int NREQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [16*NREQ-1:0] req_a,
  input  logic [16*NREQ-1:0] req_b,
  output logic [NREQ-1:0]    req_ready,
  output logic               rsp_valid,
  output logic [1:0]         rsp_id,
  output logic [31:0]        rsp_prod,
  input  logic               rsp_ready,
  output logic               busy
);
  logic        s1_valid_q, s1_valid_d;
  logic [15:0] s1_a_q, s1_a_d;
  logic [15:0] s1_b_q, s1_b_d;
  logic [1:0]  s1_id_q, s1_id_d;
  logic        s2_valid_q, s2_valid_d;
  logic [31:0] s2_prod_q, s2_prod_d;
  logic [1:0]  s2_id_q, s2_id_d;
  logic [1:0]  last_grant_q, last_grant_d;

  logic        s2_load, s1_load, accept, win_found;
  logic [1:0]  win_id;
  logic [31:0] mult_prod;

  assign s2_load = !s2_valid_q || rsp_ready;
  assign s1_load = !s1_valid_q || s2_load;

  // Search begins one past the last accepted requester; index wraps mod 4.
  always_comb begin : arbiter
    logic [1:0] idx;
    idx       = '0;
    win_found = 1'b0;
    win_id    = last_grant_q;
    for (int k = 1; k <= NREQ; k++) begin
      idx = last_grant_q + 2'(k);
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
    assign req_ready[gi] = !rst && s1_load && win_found && (win_id == 2'(gi));
  end

  assign accept = |req_ready;

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_a_d       = s1_a_q;
    s1_b_d       = s1_b_q;
    s1_id_d      = s1_id_q;
    s2_valid_d   = s2_valid_q;
    s2_prod_d    = s2_prod_q;
    s2_id_d      = s2_id_q;
    last_grant_d = last_grant_q;

    if (accept) begin
      s1_valid_d   = 1'b1;
      s1_a_d       = req_a[16*win_id +: 16];
      s1_b_d       = req_b[16*win_id +: 16];
      s1_id_d      = win_id;
      last_grant_d = win_id;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end

    // Product data only changes when a real operation moves in, so the
    // response stays put while it is stalled or after it drains.
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_prod_d = mult_prod;
        s2_id_d   = s1_id_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_id_q      <= '0;
      s2_valid_q   <= 1'b0;
      s2_prod_q    <= '0;
      s2_id_q      <= '0;
      last_grant_q <= 2'd3;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      s1_id_q      <= s1_id_d;
      s2_valid_q   <= s2_valid_d;
      s2_prod_q    <= s2_prod_d;
      s2_id_q      <= s2_id_d;
      last_grant_q <= last_grant_d;
    end
  end

  wallace_mult16 u_mult (
    .a    (s1_a_q),
    .b    (s1_b_q),
    .prod (mult_prod)
  );

  assign rsp_valid = s2_valid_q;
  assign rsp_id    = s2_id_q;
  assign rsp_prod  = s2_prod_q;
  assign busy      = s1_valid_q || s2_valid_q;
endmodule

// Unsigned 16x16 multiplier: partial-product rows reduced by layers of 3:2
// carry-save compressors down to two rows, then one final adder.
module wallace_mult16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] prod
);
  localparam int NLVL = 7;  // 16 -> 11 -> 8 -> 6 -> 4 -> 3 -> 2 rows

  function automatic int rows_at(input int lvl);
    int n;
    n = 16;
    for (int k = 0; k < lvl; k++) n = 2 * (n / 3) + n % 3;
    return n;
  endfunction

  logic [31:0] row [NLVL][16];

  for (genvar gi = 0; gi < 16; gi++) begin : g_pp
    assign row[0][gi] = b[gi] ? (32'(a) << gi) : 32'd0;
  end

  for (genvar gl = 0; gl < NLVL - 1; gl++) begin : g_lvl
    localparam int N = rows_at(gl);
    localparam int G = N / 3;
    localparam int M = rows_at(gl + 1);
    for (genvar gi = 0; gi < G; gi++) begin : g_csa
      assign row[gl+1][2*gi]   = row[gl][3*gi] ^ row[gl][3*gi+1] ^ row[gl][3*gi+2];
      assign row[gl+1][2*gi+1] = ((row[gl][3*gi]   & row[gl][3*gi+1]) |
                                  (row[gl][3*gi]   & row[gl][3*gi+2]) |
                                  (row[gl][3*gi+1] & row[gl][3*gi+2])) << 1;
    end
    for (genvar gi = 0; gi < N % 3; gi++) begin : g_pass
      assign row[gl+1][2*G+gi] = row[gl][3*G+gi];
    end
    for (genvar gi = M; gi < 16; gi++) begin : g_zero
      assign row[gl+1][gi] = 32'd0;
    end
  end

  // A 16x16 product always fits in 32 bits, so the final carry-out is dropped.
  assign prod = row[NLVL-1][0] + row[NLVL-1][1];
endmodule
